// File: rtl/bounds_sequencer.sv
// bounds_sequencer: latches a frame's finder-pattern projections, runs the bounds finder
// with a timeout, sanity-checks the resulting window and offers it to the sampler.
module bounds_sequencer #(
    parameter int WIDTH     = 480,
    parameter int TIMEOUT   = 1100,
    parameter int MIN_SIZE  = 64,
    parameter int SKEW_TOL  = 32,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             frame_done_in,
    input  logic [WIDTH-1:0] horz_in,
    input  logic [WIDTH-1:0] vert_in,
    output logic [WIDTH-1:0] horz_patterns_out,
    output logic [WIDTH-1:0] vert_patterns_out,
    output logic             bounds_rst_out,
    output logic             start_bound_out,
    input  logic [8:0]       bound_x0_in,
    input  logic [8:0]       bound_x1_in,
    input  logic [8:0]       bound_y0_in,
    input  logic [8:0]       bound_y1_in,
    input  logic             valid_bound_in,
    output logic [8:0]       crop_x0_out,
    output logic [8:0]       crop_x1_out,
    output logic [8:0]       crop_y0_out,
    output logic [8:0]       crop_y1_out,
    output logic             crop_valid_out,
    input  logic             crop_ready_in,
    output logic             fail_out,
    output logic             busy_out
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
    localparam logic signed [9:0] MIN_S = 10'(MIN_SIZE);
    localparam logic [9:0] SKEW_S = 10'(SKEW_TOL);

    typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, CHECK, PRESENT, FAIL} state_t;

    state_t          state;
    logic [TW-1:0]   tmo_cnt;
    logic [RW-1:0]   retry_cnt;
    logic [RW-1:0]   retry_nxt;
    logic [8:0]      bx0, bx1, by0, by1;
    logic signed [9:0] w, h, d;
    logic [9:0]      d_abs;
    logic            accept;

    always_comb begin
        w = $signed({1'b0, bx1}) - $signed({1'b0, bx0});
        h = $signed({1'b0, by1}) - $signed({1'b0, by0});
        d = w - h;
        d_abs = d[9] ? -d : d;
        accept = (bx1 > bx0) && (by1 > by0) && (w >= MIN_S) && (h >= MIN_S) && (d_abs <= SKEW_S);
        retry_nxt = (retry_cnt == RMAX) ? retry_cnt : retry_cnt + RW'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= IDLE;
            tmo_cnt           <= '0;
            retry_cnt         <= '0;
            {bx0, bx1, by0, by1} <= '0;
            horz_patterns_out <= '0;
            vert_patterns_out <= '0;
            bounds_rst_out    <= 1'b0;
            start_bound_out   <= 1'b0;
            crop_x0_out       <= '0;
            crop_x1_out       <= '0;
            crop_y0_out       <= '0;
            crop_y1_out       <= '0;
            crop_valid_out    <= 1'b0;
            fail_out          <= 1'b0;
            busy_out          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (frame_done_in) begin
                    horz_patterns_out <= horz_in;
                    vert_patterns_out <= vert_in;
                    bounds_rst_out    <= 1'b1;
                    busy_out          <= 1'b1;
                    state             <= CLEAR;
                end
                CLEAR: begin
                    bounds_rst_out  <= 1'b0;
                    start_bound_out <= 1'b1;
                    state           <= START;
                end
                START: begin
                    start_bound_out <= 1'b0;
                    tmo_cnt         <= '0;
                    state           <= WAIT;
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    // a timeout feeds an all-zero window into CHECK, which always rejects it
                    if (valid_bound_in) begin
                        {bx0, bx1, by0, by1} <= {bound_x0_in, bound_x1_in, bound_y0_in, bound_y1_in};
                        state <= CHECK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        {bx0, bx1, by0, by1} <= '0;
                        state <= CHECK;
                    end
                end
                CHECK: if (accept) begin
                    {crop_x0_out, crop_x1_out, crop_y0_out, crop_y1_out} <= {bx0, bx1, by0, by1};
                    retry_cnt      <= '0;
                    crop_valid_out <= 1'b1;
                    state          <= PRESENT;
                end else begin
                    retry_cnt <= retry_nxt;
                    if (retry_nxt == RMAX) begin
                        fail_out <= 1'b1;
                        state    <= FAIL;
                    end else begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                end
                PRESENT: if (crop_ready_in) begin
                    crop_valid_out <= 1'b0;
                    busy_out       <= 1'b0;
                    state          <= IDLE;
                end
                FAIL: begin
                    fail_out  <= 1'b0;
                    retry_cnt <= '0;
                    busy_out  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
